// File: rtl/list_walk_master.sv
// Bus master on the picorv32 native memory port: walks a singly linked list of {next, payload} nodes
// and streams each payload out. Optional bus timeout is enabled by defining LIST_WALK_TIMEOUT_EN.
module list_walk_master #(
    parameter int MAX_NODES      = 255,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] start_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        limit_hit,
    output logic [15:0] node_count,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD_NEXT, GAP_D, RD_DATA, EMIT, FIN} state_t;

    state_t      state_reg, state_next;
    logic [31:0] node_reg, link_reg, data_out_reg;
    logic [15:0] node_count_reg;
    logic        data_valid_reg, busy_reg, error_reg, limit_hit_reg;
    logic        timeout, handshake, last_node, start_ok;

    assign handshake = (state_reg == EMIT) && data_ready;
    assign last_node = ({1'b0, node_count_reg} + 17'd1) == 17'(MAX_NODES);
    assign start_ok  = (start_addr != 32'd0) && (start_addr[1:0] == 2'b00);

`ifdef LIST_WALK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_reg;

    // Counts stalled request cycles; the idle gap between requests clears it.
    always_ff @(posedge clk) begin
        if (!resetn || !mem_valid || mem_ready) begin
            wait_reg <= '0;
        end else begin
            wait_reg <= wait_reg + 1'b1;
        end
    end
    assign timeout = mem_valid && !mem_ready && (wait_reg == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = start_ok ? RD_NEXT : FIN;
                end
            end
            RD_NEXT: begin
                if (mem_ready) begin
                    state_next = GAP_D;
                end else if (timeout) begin
                    state_next = FIN;
                end
            end
            GAP_D: state_next = RD_DATA;
            RD_DATA: begin
                if (mem_ready) begin
                    state_next = EMIT;
                end else if (timeout) begin
                    state_next = FIN;
                end
            end
            EMIT: begin
                if (data_ready) begin
                    if (link_reg == 32'd0 || link_reg[1:0] != 2'b00 || last_node) begin
                        state_next = FIN;
                    end else begin
                        state_next = RD_NEXT;
                    end
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = node_reg;
        done      = 1'b0;
        case (state_reg)
            RD_NEXT: mem_valid = 1'b1;
            RD_DATA: begin
                mem_valid = 1'b1;
                mem_addr  = node_reg + 32'd4;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            node_reg       <= '0;
            link_reg       <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            node_count_reg <= '0;
            busy_reg       <= 1'b0;
            error_reg      <= 1'b0;
            limit_hit_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        node_count_reg <= '0;
                        limit_hit_reg  <= 1'b0;
                        error_reg      <= |start_addr[1:0];
                        if (start_ok) begin
                            node_reg <= start_addr;
                            busy_reg <= 1'b1;
                        end
                    end
                end
                RD_NEXT: begin
                    if (mem_ready) begin
                        link_reg <= mem_rdata;
                    end else if (timeout) begin
                        error_reg <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (mem_ready) begin
                        data_out_reg   <= mem_rdata;
                        data_valid_reg <= 1'b1;
                    end else if (timeout) begin
                        error_reg <= 1'b1;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        data_valid_reg <= 1'b0;
                        if (node_count_reg != 16'hFFFF) begin
                            node_count_reg <= node_count_reg + 16'd1;
                        end
                        // Null link ends cleanly; a bad link or the node limit flags why the walk stopped.
                        if (link_reg == 32'd0) begin
                            error_reg <= 1'b0;
                        end else if (link_reg[1:0] != 2'b00) begin
                            error_reg <= 1'b1;
                        end else if (last_node) begin
                            limit_hit_reg <= 1'b1;
                        end else begin
                            node_reg <= link_reg;
                        end
                    end
                end
                FIN:     busy_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy       = busy_reg;
    assign error      = error_reg;
    assign limit_hit  = limit_hit_reg;
    assign node_count = node_count_reg;
    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign mem_instr  = 1'b0;
    assign mem_wdata  = 32'd0;
    assign mem_wstrb  = 4'd0;
endmodule
